// File: rtl/sad_window_scanner_pkg.sv
// rtl/sad_window_scanner_pkg.sv - shared opcodes, scan states and default widths for the SAD window scanner
// Contents:
//   COORD_W_DEF      default coordinate counter width
//   SAD_OP_*         ALUOp encodings recognised when SADOp is asserted
//   sad_state_t      scan FSM states (IDLE, SCAN, DONE)
package sad_pkg;

    localparam int COORD_W_DEF = 16;

    localparam logic [5:0] SAD_OP_FRAME_W = 6'b111100;
    localparam logic [5:0] SAD_OP_FRAME_H = 6'b111101;
    localparam logic [5:0] SAD_OP_WINDOW  = 6'b111110;
    localparam logic [5:0] SAD_OP_STRIDE  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sad_state_t;

endpackage

// File: rtl/sad_window_scanner_if.sv
// rtl/sad_window_scanner_if.sv - config, position stream and status bundle of the SAD window scanner
// Signals:
//   SADOp/ALUOp/Width/Height   config write from the ALU decode
//   Start                      single-cycle scan request
//   PosValid/PosReady          position stream handshake
//   PosX/PosY/PosAddr          window origin and its linear address
//   FrameWidth..MemHeight      current geometry registers
//   Busy/Done/CfgErr           scan status and rejection pulse
// Modports: master drives config and PosReady; slave is the scanner.
interface sad_window_scanner_if #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = sad_pkg::COORD_W_DEF,
    parameter int ADDR_W  = 32
);
    logic               SADOp;
    logic [5:0]         ALUOp;
    logic [DATA_W-1:0]  Width;
    logic [DATA_W-1:0]  Height;
    logic               Start;
    logic               PosReady;
    logic               PosValid;
    logic [COORD_W-1:0] PosX;
    logic [COORD_W-1:0] PosY;
    logic [ADDR_W-1:0]  PosAddr;
    logic [COORD_W-1:0] FrameWidth;
    logic [COORD_W-1:0] FrameHeight;
    logic [COORD_W-1:0] MemWidth;
    logic [COORD_W-1:0] MemHeight;
    logic               Busy;
    logic               Done;
    logic               CfgErr;

    modport master (
        output SADOp, ALUOp, Width, Height, Start, PosReady,
        input  PosValid, PosX, PosY, PosAddr,
        input  FrameWidth, FrameHeight, MemWidth, MemHeight,
        input  Busy, Done, CfgErr
    );

    modport slave (
        input  SADOp, ALUOp, Width, Height, Start, PosReady,
        output PosValid, PosX, PosY, PosAddr,
        output FrameWidth, FrameHeight, MemWidth, MemHeight,
        output Busy, Done, CfgErr
    );
endinterface

// File: rtl/sad_window_scanner_pos_counter.sv
// rtl/sad_window_scanner_pos_counter.sv - 2-D window origin stepping counter with incremental row base
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               return x/y/row base/address to 0 (wins over advance)
//   advance             step to the next origin
//   limit_x, limit_y    largest legal origin column/row
//   step                column/row increment
//   row_step            address increment for one row step (frame width * step)
//   x, y, addr          current origin and linear address
//   wrap_x, wrap_y      next column/row step would pass its limit
//   last                current origin is the final one
module sad_pos_counter #(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    input  logic [COORD_W-1:0] limit_x,
    input  logic [COORD_W-1:0] limit_y,
    input  logic [COORD_W-1:0] step,
    input  logic [ADDR_W-1:0]  row_step,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               wrap_x,
    output logic               wrap_y,
    output logic               last
);
    logic [COORD_W:0]  x_next;
    logic [COORD_W:0]  y_next;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_next;

    // One extra bit so x+step cannot wrap around and look in range.
    assign x_next        = {1'b0, x} + {1'b0, step};
    assign y_next        = {1'b0, y} + {1'b0, step};
    assign wrap_x        = x_next > {1'b0, limit_x};
    assign wrap_y        = y_next > {1'b0, limit_y};
    assign last          = wrap_x && wrap_y;
    assign row_base_next = row_base + row_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (clear) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (advance) begin
            if (!wrap_x) begin
                x    <= x_next[COORD_W-1:0];
                addr <= addr + ADDR_W'(step);
            end else if (!wrap_y) begin
                x        <= '0;
                y        <= y_next[COORD_W-1:0];
                row_base <= row_base_next;
                addr     <= row_base_next;
            end
        end
    end
endmodule

// File: rtl/sad_window_scanner.sv
// rtl/sad_window_scanner.sv - SAD geometry registers plus scan engine walking every window origin in the frame
// Ports:
//   Clk     clock, rising edge
//   Rst_n   asynchronous active-low reset; clears geometry and aborts any scan
//   bus     sad_window_scanner_if.slave: config writes, Start, position stream, status
// Optional feature: define SAD_STRIDE_EN to add a Stride register (opcode 111111) used as the
// column/row step; otherwise the step is fixed at 1 and opcode 111111 is ignored.
module sad_window_scanner
    import sad_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COORD_W = COORD_W_DEF,
    parameter int ADDR_W  = 32
) (
    input logic                 Clk,
    input logic                 Rst_n,
    sad_window_scanner_if.slave bus
);
    sad_state_t state_q, state_d;

    logic [COORD_W-1:0] frame_w, frame_h, mem_w, mem_h;
    logic [COORD_W-1:0] frame_w_n, frame_h_n, mem_w_n, mem_h_n;
    logic [COORD_W-1:0] width_lo, height_lo;
    logic [DATA_W-1:0]  width_hi, height_hi;
    logic               w_trunc, h_trunc;
    logic               idle, op_fw, op_fh, op_win, op_str, op_any;
    logic               wr_fw, wr_fh, wr_win;
    logic               cfg_bad, cfg_busy, geom_ok, start_ok, start_bad;
    logic               cfg_err_q;
    logic               pos_valid, busy, done;
    logic               handshake, cnt_clear, wrap_x, wrap_y, last;
    logic [COORD_W-1:0] step;
    logic [ADDR_W-1:0]  row_step;
    logic [COORD_W-1:0] pos_x, pos_y;
    logic [ADDR_W-1:0]  pos_addr;

    assign idle      = (state_q == IDLE);
    assign width_lo  = bus.Width[COORD_W-1:0];
    assign height_lo = bus.Height[COORD_W-1:0];
    assign width_hi  = bus.Width >> COORD_W;
    assign height_hi = bus.Height >> COORD_W;
    assign w_trunc   = (width_hi != '0);
    assign h_trunc   = (height_hi != '0);

    assign op_fw  = bus.SADOp && (bus.ALUOp == SAD_OP_FRAME_W);
    assign op_fh  = bus.SADOp && (bus.ALUOp == SAD_OP_FRAME_H);
    assign op_win = bus.SADOp && (bus.ALUOp == SAD_OP_WINDOW);
    assign op_any = op_fw || op_fh || op_win || op_str;

    assign wr_fw  = idle && op_fw && !w_trunc;
    assign wr_fh  = idle && op_fh && !h_trunc;
    assign wr_win = idle && op_win && !w_trunc && !h_trunc;

    // Post-write geometry: a Start in the same cycle as a config write validates these.
    assign frame_w_n = wr_fw  ? width_lo  : frame_w;
    assign frame_h_n = wr_fh  ? height_lo : frame_h;
    assign mem_w_n   = wr_win ? width_lo  : mem_w;
    assign mem_h_n   = wr_win ? height_lo : mem_h;

`ifdef SAD_STRIDE_EN
    logic [COORD_W-1:0]   stride;
    logic [2*COORD_W-1:0] row_prod;

    assign op_str   = bus.SADOp && (bus.ALUOp == SAD_OP_STRIDE);
    assign step     = stride;
    // Geometry is frozen for the whole scan, so this product is a per-scan constant.
    assign row_prod = frame_w * stride;
    assign row_step = ADDR_W'(row_prod);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stride <= COORD_W'(1);
        end else if (idle && op_str && !w_trunc && (width_lo != '0)) begin
            stride <= width_lo;
        end
    end

    assign cfg_bad = idle && ((op_fw && w_trunc) || (op_fh && h_trunc) ||
                              (op_win && (w_trunc || h_trunc)) ||
                              (op_str && (w_trunc || (width_lo == '0))));
`else
    assign op_str   = 1'b0;
    assign step     = COORD_W'(1);
    assign row_step = ADDR_W'(frame_w);

    assign cfg_bad = idle && ((op_fw && w_trunc) || (op_fh && h_trunc) ||
                              (op_win && (w_trunc || h_trunc)));
`endif

    assign cfg_busy  = !idle && op_any;
    assign geom_ok   = (frame_w_n != '0) && (frame_h_n != '0) &&
                       (mem_w_n != '0) && (mem_h_n != '0) &&
                       (mem_w_n <= frame_w_n) && (mem_h_n <= frame_h_n);
    assign start_ok  = idle && bus.Start && geom_ok;
    assign start_bad = idle && bus.Start && !geom_ok;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            frame_w   <= '0;
            frame_h   <= '0;
            mem_w     <= '0;
            mem_h     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            frame_w   <= frame_w_n;
            frame_h   <= frame_h_n;
            mem_w     <= mem_w_n;
            mem_h     <= mem_h_n;
            cfg_err_q <= cfg_bad || cfg_busy || start_bad;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                pos_valid = 1'b1;
                busy      = 1'b1;
                if (bus.PosReady && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign handshake = pos_valid && bus.PosReady;
    // Counter is zeroed both when a scan starts and as the final position is taken,
    // so the position outputs read 0 outside a scan.
    assign cnt_clear = start_ok || (handshake && last);

    sad_pos_counter #(
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
    ) u_pos_counter (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .clear    (cnt_clear),
        .advance  (handshake),
        .limit_x  (frame_w - mem_w),
        .limit_y  (frame_h - mem_h),
        .step     (step),
        .row_step (row_step),
        .x        (pos_x),
        .y        (pos_y),
        .addr     (pos_addr),
        .wrap_x   (wrap_x),
        .wrap_y   (wrap_y),
        .last     (last)
    );

    assign bus.PosValid    = pos_valid;
    assign bus.PosX        = pos_x;
    assign bus.PosY        = pos_y;
    assign bus.PosAddr     = pos_addr;
    assign bus.FrameWidth  = frame_w;
    assign bus.FrameHeight = frame_h;
    assign bus.MemWidth    = mem_w;
    assign bus.MemHeight   = mem_h;
    assign bus.Busy        = busy;
    assign bus.Done        = done;
    assign bus.CfgErr      = cfg_err_q;
endmodule
